// File: rtl/int_normalizer.sv
// int_normalizer: takes a signed 32-bit integer, forms its magnitude and
// left-normalizes it with an iterative shifter (byte steps, then bit steps).
// Produces sign, biased exponent (bias 127) and a mantissa with bit 31 set.
// Handshakes on both sides are valid/ready: a transfer happens on a rising
// clock edge where valid and ready are both 1; a producer holds valid and
// its data stable until that edge.
module int_normalizer (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [31:0] IN_DATA,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic        OUT_SIGN,
   output logic [7:0]  OUT_EXP,
   output logic [31:0] OUT_MANT,
   output logic        OUT_ZERO,
   output logic [1:0]  DBG_STATE
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic        sign_q;
   logic [31:0] mag_q;
   logic [5:0]  cnt_q;
   logic        out_valid_q;
   logic        out_sign_q;
   logic [7:0]  out_exp_q;
   logic [31:0] out_mant_q;
   logic        out_zero_q;
   logic [31:0] abs_d;

   // Magnitude of the incoming value; -2^31 maps to 0x80000000 unchanged.
   always_comb begin
      abs_d = IN_DATA;
      if (IN_DATA[31]) begin
         abs_d = (~IN_DATA) + 32'd1;
      end
   end

   // Control FSM with datapath registers and registered result outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         mag_q       <= 32'd0;
         cnt_q       <= 6'd0;
         out_valid_q <= 1'b0;
         out_sign_q  <= 1'b0;
         out_exp_q   <= 8'd0;
         out_mant_q  <= 32'd0;
         out_zero_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (IN_VALID) begin
                  sign_q <= IN_DATA[31];
                  mag_q  <= abs_d;
                  cnt_q  <= 6'd0;
                  if (abs_d == 32'd0) begin
                     // Zero has no leading one; report it directly.
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                     out_zero_q  <= 1'b1;
                     out_sign_q  <= 1'b0;
                     out_exp_q   <= 8'd0;
                     out_mant_q  <= 32'd0;
                  end else begin
                     state_q <= NORM;
                  end
               end
            end
            NORM: begin
               if (mag_q[31]) begin
                  // cnt equals the leading-zero count here, so msb = 31 - cnt.
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  out_exp_q   <= 8'd158 - {2'b00, cnt_q};
                  out_mant_q  <= mag_q;
                  out_sign_q  <= sign_q;
                  out_zero_q  <= 1'b0;
               end else if (mag_q[31:24] == 8'd0) begin
                  mag_q <= mag_q << 8;
                  cnt_q <= cnt_q + 6'd8;
               end else begin
                  mag_q <= mag_q << 1;
                  cnt_q <= cnt_q + 6'd1;
               end
            end
            DONE: begin
               if (OUT_READY) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign IN_READY  = (state_q == IDLE);
   assign OUT_VALID = out_valid_q;
   assign OUT_SIGN  = out_sign_q;
   assign OUT_EXP   = out_exp_q;
   assign OUT_MANT  = out_mant_q;
   assign OUT_ZERO  = out_zero_q;
   assign DBG_STATE = state_q;

endmodule
